crc32_sched: RTL and testbench
==============================

CRC32_SCHED -- requirements
Module: crc32_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing one crc32 engine (2..8).
REQ-002 Parameter ENG_LAT, default 32, is the number of cycles eng_compute_o is held high per job.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 req_valid_i  input  NUM_REQ  per-requester job request.
REQ-006 req_ready_o  output  NUM_REQ  one-hot accept pulse; a job transfers when valid and ready are both high.
REQ-007 req_data_i  input  NUM_REQ*32  per-requester message word; requester n uses slice [32n+31:32n].
REQ-008 req_poly_i  input  NUM_REQ*32  per-requester polynomial, same slicing.
REQ-009 eng_message_o  output  32  message to engine message_i.
REQ-010 eng_polynomial_o  output  32  polynomial to engine polynomial_i.
REQ-011 eng_compute_o  output  1  engine compute_i.
REQ-012 eng_clear_o  output  1  one-cycle engine state clear before each job.
REQ-013 eng_result_i  input  32  engine message_o.
REQ-014 rsp_valid_o  output  1  result available.
REQ-015 rsp_ready_i  input  1  result consumer ready.
REQ-016 rsp_id_o  output  clog2(NUM_REQ)  index of the served requester.
REQ-017 rsp_crc_o  output  32  captured CRC result.
REQ-018 busy_o  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, LOAD, RUN, RESP.
REQ-020 IDLE: when any req_valid_i is high, the arbiter grants exactly one requester, req_ready_o[g] is high for that cycle only, data/poly/id are latched, and the next state is LOAD.
REQ-021 Arbitration is round-robin: search starts at pointer ptr; after a grant to g, ptr becomes (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-022 LOAD: eng_clear_o is 1 for exactly one cycle, eng_compute_o is 0, and the next state is RUN.
REQ-023 RUN: eng_compute_o is 1 for exactly ENG_LAT consecutive cycles, counted 0..ENG_LAT-1; at count ENG_LAT-1 the next state is RESP.
REQ-024 eng_message_o and eng_polynomial_o hold the latched values from LOAD through the last RUN cycle and are 0 in IDLE.
REQ-025 On the RUN->RESP edge, eng_result_i is registered into rsp_crc_o.
REQ-026 RESP: rsp_valid_o stays high, with rsp_id_o and rsp_crc_o stable, until rsp_ready_i is high; the handshake cycle returns the FSM to IDLE.
REQ-027 Latency: a job accepted at cycle T asserts rsp_valid_o at T+2+ENG_LAT; minimum accept-to-accept spacing is ENG_LAT+3 cycles.
REQ-028 req_ready_o is 0 in LOAD, RUN and RESP; requests arriving then wait without loss, and req_valid_i may deassert before grant.
REQ-029 rsp_ready_i high while rsp_valid_o is low has no effect.

Reset
REQ-030 While rst_i is high at a clock edge: state = IDLE, ptr = 0, counter = 0, and every output is 0, including rsp_crc_o and rsp_id_o.
REQ-031 Reset asserted mid-job (LOAD/RUN/RESP) aborts the job without producing a response and drops eng_compute_o on the next edge.
REQ-032 The first grant after reset goes to the lowest-index valid requester.

Structure
REQ-033 Package crc32_sched_pkg holds the state enum, CRC_W = 32 and the default ENG_LAT.
REQ-034 Arbitration is a sub-module rr_arbiter (inputs: request vector, pointer, enable; outputs: one-hot grant, grant index); the FSM and datapath stay in crc32_sched.

Verification
REQ-035 Single job: req_valid_i[0] with data 0xFFEEFFEE and poly 0x04C11DB7, rsp_ready_i = 1 -> rsp_valid_o at accept+34, rsp_id_o = 0, rsp_crc_o equals the reference-model CRC, eng_compute_o high for exactly 32 cycles.
REQ-036 All four requesters held valid -> grants in order 0,1,2,3,0 and each rsp_id_o matches its grant.
REQ-037 Backpressure: rsp_ready_i held 0 for 5 cycles in RESP -> rsp_valid_o/rsp_crc_o stable, no new grant, IDLE on the 6th cycle.
REQ-038 Wrap: serve requester 3, then requesters 0 and 3 valid together -> grant 0.
REQ-039 rst_i pulsed at RUN count 10 -> next cycle all outputs 0, no response, following job served from requester 0 with correct CRC.

Source files
------------

// File: rtl/crc32_sched_pkg.sv
// Shared definitions for the crc32 job scheduler.
//   CRC_W        width of message, polynomial and result words
//   ENG_LAT_DEF  default number of engine compute cycles per job
//   state_e      scheduler FSM encoding
//   idx_w()      index width helper that never returns zero
package crc32_sched_pkg;

  localparam int CRC_W       = 32;
  localparam int ENG_LAT_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/crc32_sched_if.sv
// Bus bundle between requesters, the shared crc32 engine, the response
// consumer and the scheduler.
//   req_*  : per-requester valid/ready handshake, message word and polynomial
//   eng_*  : drive and result lines of the crc32 engine
//   rsp_*  : response handshake with requester id and captured CRC
//   busy_o : scheduler not idle
// Modports: slave = the scheduler, master = the surrounding environment.
interface crc32_sched_if #(
  parameter int NUM_REQ = 4
);
  import crc32_sched_pkg::*;

  localparam int ID_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ*CRC_W-1:0] req_data_i;
  logic [NUM_REQ*CRC_W-1:0] req_poly_i;
  logic [CRC_W-1:0]         eng_message_o;
  logic [CRC_W-1:0]         eng_polynomial_o;
  logic                     eng_compute_o;
  logic                     eng_clear_o;
  logic [CRC_W-1:0]         eng_result_i;
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [ID_W-1:0]          rsp_id_o;
  logic [CRC_W-1:0]         rsp_crc_o;
  logic                     busy_o;

  modport slave (
    input  req_valid_i, req_data_i, req_poly_i, eng_result_i, rsp_ready_i,
    output req_ready_o, eng_message_o, eng_polynomial_o, eng_compute_o,
           eng_clear_o, rsp_valid_o, rsp_id_o, rsp_crc_o, busy_o
  );

  modport master (
    output req_valid_i, req_data_i, req_poly_i, eng_result_i, rsp_ready_i,
    input  req_ready_o, eng_message_o, eng_polynomial_o, eng_compute_o,
           eng_clear_o, rsp_valid_o, rsp_id_o, rsp_crc_o, busy_o
  );

endinterface

// File: rtl/crc32_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req  request vector
//   i_ptr  index where the search starts (highest priority this cycle)
//   i_en   grant enable; no grant is produced when low
//   o_gnt  one-hot grant
//   o_idx  binary index of the granted requester (0 when no grant)
module rr_arbiter
  import crc32_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  localparam int KW = IDX_W + 1;

  always_comb begin
    logic [KW-1:0]    k;
    logic [IDX_W-1:0] idx;
    logic             found;
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    k     = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // rotated position; one extra bit so the wrap can be folded back
      k = {1'b0, i_ptr} + KW'(i);
      if (k >= KW'(NUM_REQ)) k = k - KW'(NUM_REQ);
      idx = k[IDX_W-1:0];
      if (i_en && !found && i_req[idx]) begin
        found      = 1'b1;
        o_gnt[idx] = 1'b1;
        o_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/crc32_sched.sv
// Shares one crc32 engine between NUM_REQ requesters. A round-robin grant
// latches the requester's message/polynomial, the engine is cleared for one
// cycle, computes for ENG_LAT cycles, and the result is held on the response
// port until the consumer takes it.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : crc32_sched_if slave (request, engine and response lines)
//
// state | meaning
// IDLE  | waiting for a request; arbiter enabled, grant pulses req_ready_o
// LOAD  | latched job on engine inputs, eng_clear_o high for one cycle
// RUN   | eng_compute_o high, counter 0..ENG_LAT-1
// RESP  | rsp_valid_o high until rsp_ready_i
module crc32_sched
  import crc32_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ENG_LAT = ENG_LAT_DEF
) (
  input logic          clk_i,
  input logic          rst_i,
  crc32_sched_if.slave bus
);

  localparam int ID_W  = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(ENG_LAT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENG_LAT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] LOAD = ST_LOAD;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] RESP = ST_RESP;

  logic [1:0]         r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_cnt;
  logic [CRC_W-1:0]   r_data;
  logic [CRC_W-1:0]   r_poly;
  logic [CRC_W-1:0]   r_crc;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_arb_en;
  logic               w_drive_eng;
  logic [CRC_W-1:0]   w_sel_data;
  logic [CRC_W-1:0]   w_sel_poly;

  // Gated by reset so no accept pulse can appear while reset is applied.
  assign w_arb_en = (r_state == IDLE) && !rst_i;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req (bus.req_valid_i),
    .i_ptr (r_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx)
  );

  // One-hot mux of the granted requester's job words.
  always_comb begin
    w_sel_data = '0;
    w_sel_poly = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (w_gnt[n]) begin
        w_sel_data = bus.req_data_i[n*CRC_W +: CRC_W];
        w_sel_poly = bus.req_poly_i[n*CRC_W +: CRC_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_poly  <= '0;
      r_crc   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_data  <= w_sel_data;
            r_poly  <= w_sel_poly;
            r_id    <= w_gnt_idx;
            r_ptr   <= (w_gnt_idx == ID_LAST) ? '0 : w_gnt_idx + ID_W'(1);
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          if (r_cnt == CNT_LAST) begin
            r_crc   <= bus.eng_result_i;
            r_cnt   <= '0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_drive_eng = (r_state == LOAD) || (r_state == RUN);

  assign bus.req_ready_o      = w_gnt;
  assign bus.eng_message_o    = w_drive_eng ? r_data : '0;
  assign bus.eng_polynomial_o = w_drive_eng ? r_poly : '0;
  assign bus.eng_clear_o      = (r_state == LOAD);
  assign bus.eng_compute_o    = (r_state == RUN);
  assign bus.rsp_valid_o      = (r_state == RESP);
  assign bus.rsp_id_o         = r_id;
  assign bus.rsp_crc_o        = r_crc;
  assign bus.busy_o           = (r_state != IDLE);

endmodule

// File: tb/tb_crc32_sched.sv
// Bench for crc32_sched: a bit-serial engine model feeds eng_result_i, a
// reference CRC by polynomial long division predicts each response, and a
// scoreboard matches responses (id, crc, latency) against the queue.
`timescale 1ns/1ps
module tb_crc32_sched;

  localparam int N   = 4;
  localparam int LAT = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc32_sched_if #(.NUM_REQ(N)) bus();
  crc32_sched #(.NUM_REQ(N), .ENG_LAT(LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string info);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, info);
  endtask

  // ---------------- engine model: MSB-first serial CRC, one bit per compute cycle
  logic [31:0] e_st = '0, e_msg = '0, e_next;
  always @(posedge clk) begin
    if (bus.eng_clear_o) begin
      e_st  <= '0;
      e_msg <= bus.eng_message_o;
    end else if (bus.eng_compute_o) begin
      e_st  <= e_next;
      e_msg <= {e_msg[30:0], 1'b0};
    end
  end
  always_comb e_next = {e_st[30:0], 1'b0} ^ ((e_st[31] ^ e_msg[31]) ? bus.eng_polynomial_o : 32'h0);
  assign bus.eng_result_i = e_next;

  // ---------------- reference: remainder of m(x)*x^32 mod (x^32 + p(x))
  function automatic logic [31:0] ref_crc(input logic [31:0] m, input logic [31:0] p);
    logic [63:0] r, g;
    r = {m, 32'h0};
    g = {31'h0, 1'b1, p};
    for (int i = 63; i >= 32; i--) if (r[i]) r = r ^ (g << (i - 32));
    return r[31:0];
  endfunction

  // ---------------- stimulus state
  logic [31:0]  d_data[N];
  logic [31:0]  d_poly[N];
  logic [31:0]  fx_d[N];
  logic [31:0]  fx_p[N];
  bit           fx_use[N];
  int           pend[N];
  logic [N-1:0] acc_vec = '0;
  bit           rnd_ready = 0;

  for (genvar n = 0; n < N; n++) begin : g_pack
    assign bus.req_data_i[n*32 +: 32] = d_data[n];
    assign bus.req_poly_i[n*32 +: 32] = d_poly[n];
  end

  task automatic post_rand(input int n, input int cnt);
    pend[n] += cnt;
  endtask

  task automatic post_fixed(input int n, input logic [31:0] d, input logic [31:0] p);
    fx_d[n]   = d;
    fx_p[n]   = p;
    fx_use[n] = 1;
    pend[n]  += 1;
  endtask

  // Requester driver: drops valid after an accept, raises it while jobs remain.
  initial begin
    for (int n = 0; n < N; n++) begin
      pend[n] = 0; fx_use[n] = 0; d_data[n] = '0; d_poly[n] = '0;
    end
    bus.req_valid_i = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int n = 0; n < N; n++) begin
        if (acc_vec[n]) begin
          bus.req_valid_i[n] = 1'b0;
          pend[n]--;
        end
        if (!bus.req_valid_i[n] && pend[n] > 0) begin
          d_data[n] = fx_use[n] ? fx_d[n] : $urandom();
          d_poly[n] = fx_use[n] ? fx_p[n] : $urandom();
          fx_use[n] = 0;
          bus.req_valid_i[n] = 1'b1;
        end
      end
      acc_vec = '0;
      if (rnd_ready) bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard producer: predicts grant and pushes expected response
  typedef struct {
    int          id;
    logic [31:0] crc;
    int          due;
  } exp_t;
  exp_t sb[$];
  int   glog[$];
  int   m_ptr = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_ptr = 0;
      sb.delete();
    end else if (|bus.req_ready_o) begin
      int           g;
      logic [N-1:0] oh;
      g = -1;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (g < 0 && bus.req_valid_i[k]) g = k;
      end
      for (int i = 0; i < N; i++) if (bus.req_ready_o[i]) glog.push_back(i);
      if (g < 0) begin
        fail("grant_without_request", $sformatf("ready=0x%0h valid=0x%0h", bus.req_ready_o, bus.req_valid_i));
      end else begin
        oh = '0;
        oh[g] = 1'b1;
        check("grant", bus.req_ready_o, oh);
        sb.push_back('{id: g, crc: ref_crc(d_data[g], d_poly[g]), due: cyc + 2 + LAT});
        m_ptr = (g + 1) % N;
      end
      acc_vec = bus.req_valid_i & bus.req_ready_o;
    end
  end

  // ---------------- monitor: response checks, compute pulse length
  bit          in_rsp = 0;
  logic [1:0]  h_id;
  logic [31:0] h_crc;
  int          run_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_rsp  = 0;
      run_len = 0;
    end else begin
      if (bus.eng_compute_o) run_len++;
      else if (run_len > 0) begin
        check("compute_len", run_len, LAT);
        run_len = 0;
      end
      if (bus.rsp_valid_o) begin
        if (!in_rsp) begin
          in_rsp = 1;
          h_id   = bus.rsp_id_o;
          h_crc  = bus.rsp_crc_o;
          if (sb.size() == 0) begin
            fail("unexpected_rsp", $sformatf("id=%0d crc=0x%0h with nothing outstanding", bus.rsp_id_o, bus.rsp_crc_o));
          end else begin
            check("rsp_id", bus.rsp_id_o, sb[0].id);
            check("rsp_crc", bus.rsp_crc_o, sb[0].crc);
            check("rsp_latency", cyc, sb[0].due);
          end
        end else begin
          check("rsp_id_stable", bus.rsp_id_o, h_id);
          check("rsp_crc_stable", bus.rsp_crc_o, h_crc);
        end
        check("no_grant_in_resp", bus.req_ready_o, 0);
        check("busy_in_resp", bus.busy_o, 1);
        if (bus.rsp_ready_i) begin
          in_rsp = 0;
          if (sb.size() > 0) void'(sb.pop_front());
        end
      end
    end
  end

  // ---------------- bounded waits
  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      int p;
      @(negedge clk);
      p = 0;
      for (int n = 0; n < N; n++) p += pend[n];
      ok = (p == 0) && (bus.req_valid_i == '0) && (sb.size() == 0) && !bus.busy_o;
    end
    if (!ok) fail("wait_idle", $sformatf("timeout after %0d cycles, busy=%0b outstanding=%0d", budget, bus.busy_o, sb.size()));
  endtask

  task automatic wait_sig(input bit want_rsp, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = want_rsp ? bus.rsp_valid_o : bus.eng_compute_o;
    end
    if (!ok) begin
      if (want_rsp) fail("wait_rsp_valid", "timeout");
      else          fail("wait_compute", "timeout");
    end
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_req_ready"},  bus.req_ready_o, 0);
    check({tag, "_eng_msg"},    bus.eng_message_o, 0);
    check({tag, "_eng_poly"},   bus.eng_polynomial_o, 0);
    check({tag, "_eng_comp"},   bus.eng_compute_o, 0);
    check({tag, "_eng_clear"},  bus.eng_clear_o, 0);
    check({tag, "_rsp_valid"},  bus.rsp_valid_o, 0);
    check({tag, "_rsp_id"},     bus.rsp_id_o, 0);
    check({tag, "_rsp_crc"},    bus.rsp_crc_o, 0);
    check({tag, "_busy"},       bus.busy_o, 0);
  endtask

  // ---------------- sequence
  int exp_rr[5]   = '{0, 1, 2, 3, 0};
  int exp_wrap[3] = '{3, 0, 3};

  initial begin
    bit ok;
    rst = 1'b1;
    bus.rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // single directed job on requester 0
    bus.rsp_ready_i = 1'b1;
    post_fixed(0, 32'hFFEEFFEE, 32'h04C11DB7);
    wait_idle(300);

    // pointer wrap: serve 3, then 0 and 3 together -> 0 first
    glog.delete();
    post_rand(3, 1);
    wait_idle(300);
    post_rand(0, 1);
    post_rand(3, 1);
    wait_idle(300);
    check("wrap_count", glog.size(), 3);
    for (int i = 0; i < 3; i++) if (i < glog.size()) check($sformatf("wrap_grant%0d", i), glog[i], exp_wrap[i]);

    // all requesters valid: rotation 0,1,2,3,0
    glog.delete();
    post_rand(0, 2);
    post_rand(1, 1);
    post_rand(2, 1);
    post_rand(3, 1);
    wait_idle(600);
    check("rr_count", glog.size(), 5);
    for (int i = 0; i < 5; i++) if (i < glog.size()) check($sformatf("rr_grant%0d", i), glog[i], exp_rr[i]);

    // backpressure: five cycles without rsp_ready, requester 2 waiting
    bus.rsp_ready_i = 1'b0;
    post_rand(1, 1);
    post_rand(2, 1);
    wait_sig(1'b1, 200, ok);
    if (ok) begin
      for (int k = 2; k <= 5; k++) begin
        @(negedge clk);
        check("bp_hold_valid", bus.rsp_valid_o, 1);
      end
      @(posedge clk);
      #1 bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      check("bp_valid_at_handshake", bus.rsp_valid_o, 1);
      @(negedge clk);
      check("bp_idle_busy", bus.busy_o, 0);
      check("bp_next_grant", bus.req_ready_o, 4'b0100);
    end
    bus.rsp_ready_i = 1'b1;
    wait_idle(300);

    // reset at RUN count 10 aborts the job
    post_rand(2, 1);
    wait_sig(1'b0, 100, ok);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("abort");
    glog.delete();
    post_rand(3, 1);
    post_rand(0, 1);
    wait_idle(300);
    check("abort_grant_count", glog.size(), 2);
    if (glog.size() > 0) check("abort_first_grant", glog[0], 0);

    // randomized traffic with random response backpressure
    rnd_ready = 1;
    for (int j = 0; j < 25; j++) begin
      post_rand($urandom_range(0, N - 1), $urandom_range(1, 2));
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    wait_idle(20000);
    rnd_ready = 0;
    bus.rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
